// File: rtl/mips_defs.sv
// Shared MIPS definitions for the execute-stage multiply/divide unit:
// MDU op encodings, default latencies, FSM state type and small helpers.
package mips_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_mdop(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_divop(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Magnitude of a two's-complement word as an unsigned value.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath. Produces the {HI, LO} result of
// mult/multu/div/divu and flags division by zero. Signed division is done
// on magnitudes through one unsigned divider and the signs are restored
// afterwards, which also keeps 0x80000000 / -1 well defined.
module mdu_calc
  import mips_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_hilo,
  output logic        o_div0
);

  logic signed [63:0] w_a_sx;
  logic signed [63:0] w_b_sx;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_s;
  logic [31:0]        w_dvd;
  logic [31:0]        w_dvs;
  logic [31:0]        w_dvs_safe;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q;
  logic [31:0]        w_r;

  assign w_a_sx   = {{32{i_a[31]}}, i_a};
  assign w_b_sx   = {{32{i_b[31]}}, i_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  assign w_div_s    = (i_op == MDU_DIV);
  assign w_dvd      = w_div_s ? mag32(i_a) : i_a;
  assign w_dvs      = w_div_s ? mag32(i_b) : i_b;
  // A zero divisor is replaced so the divider never sees x-producing input;
  // the result is discarded through o_div0 anyway.
  assign w_dvs_safe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
  assign w_q_mag    = w_dvd / w_dvs_safe;
  assign w_r_mag    = w_dvd % w_dvs_safe;

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_q = (w_div_s && (i_a[31] ^ i_b[31])) ? neg32(w_q_mag) : w_q_mag;
  assign w_r = (w_div_s && i_a[31])             ? neg32(w_r_mag) : w_r_mag;

  assign o_div0 = is_divop(i_op) && (i_b == 32'd0);

  // Select the result format for the requested operation.
  always_comb begin
    o_hilo = 64'd0;
    case (i_op)
      MDU_MULT:            o_hilo = w_prod_s;
      MDU_MULTU:           o_hilo = w_prod_u;
      MDU_DIV, MDU_DIVU:   o_hilo = {w_r, w_q};
      default:             o_hilo = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit. Owns HI/LO, runs multiplies and
// divides as fixed-latency operations and exposes start/busy so the
// decode-stage hazard logic can stall dependent MDU instructions.
module mdu_e
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic [3:0]  MDUOp_E,
  output logic        start_E,
  output logic        busy_E,
  output logic [31:0] HI_E,
  output logic [31:0] LO_E,
  output logic [31:0] MDOut_E
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_start;
  logic             w_commit;

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_div0;

  logic [63:0]      w_hilo;
  logic             w_div0;

  mdu_calc u_calc (
    .i_op   (MDUOp_E),
    .i_a    (A_E),
    .i_b    (B_E),
    .o_hilo (w_hilo),
    .o_div0 (w_div0)
  );

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: launch on a multicycle op while idle, commit when the count reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (is_mdop(MDUOp_E)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = is_divop(MDUOp_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pending result capture at launch, HI/LO update at commit or on mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend_hi   <= 32'd0;
      r_pend_lo   <= 32'd0;
      r_pend_div0 <= 1'b0;
    end else begin
      if (w_start) begin
        r_pend_hi   <= w_hilo[63:32];
        r_pend_lo   <= w_hilo[31:0];
        r_pend_div0 <= w_div0;
      end
      if (w_commit) begin
        if (!r_pend_div0) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (r_state == ST_IDLE) begin
        if (MDUOp_E == MDU_MTHI) r_hi <= A_E;
        if (MDUOp_E == MDU_MTLO) r_lo <= A_E;
      end
    end
  end

  assign start_E = w_start;
  assign busy_E  = (r_state == ST_RUN);
  assign HI_E    = r_hi;
  assign LO_E    = r_lo;
  assign MDOut_E = (MDUOp_E == MDU_MFHI) ? r_hi :
                   (MDUOp_E == MDU_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_e.sv
// Directed testbench for mdu_e with a result scoreboard.
module tb_mdu_e;
  import mips_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic [3:0]  MDUOp_E;
  logic        start_E;
  logic        busy_E;
  logic [31:0] HI_E;
  logic [31:0] LO_E;
  logic [31:0] MDOut_E;

  int ntests = 0;
  int nfail  = 0;
  logic [63:0] sb_q[$];

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .A_E     (A_E),
    .B_E     (B_E),
    .MDUOp_E (MDUOp_E),
    .start_E (start_E),
    .busy_E  (busy_E),
    .HI_E    (HI_E),
    .LO_E    (LO_E),
    .MDOut_E (MDOut_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp_E = op;
    A_E     = a;
    B_E     = b;
  endtask

  // Counts busy cycles until busy_E drops, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy_E === 1'b1 && cycles < 64) begin
      cycles++;
      tick();
    end
  endtask

  // Issue one multicycle op, check start/latency, then score HI/LO and MFHI/MFLO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    logic [63:0] e;
    drive(op, a, b);
    #1;
    chk({tag, "_start"}, {31'd0, start_E}, 32'd1);
    sb_q.push_back({ehi, elo});
    tick();
    drive(MDU_NONE, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_idle(cyc);
    chk({tag, "_busy_cycles"}, cyc, n);
    e = sb_q.pop_front();
    chk({tag, "_hi"}, HI_E, e[63:32]);
    chk({tag, "_lo"}, LO_E, e[31:0]);
    drive(MDU_MFHI, 32'd0, 32'd0);
    #1;
    chk({tag, "_mfhi"}, MDOut_E, e[63:32]);
    drive(MDU_MFLO, 32'd0, 32'd0);
    #1;
    chk({tag, "_mflo"}, MDOut_E, e[31:0]);
    drive(MDU_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [63:0] e;
    reset = 1'b1;
    drive(MDU_NONE, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy_E}, 32'd0);
    chk("reset_hi", HI_E, 32'd0);
    chk("reset_lo", LO_E, 32'd0);
    chk("reset_start", {31'd0, start_E}, 32'd0);
    chk("none_mdout", MDOut_E, 32'd0);

    // Multiplies
    run_op("mult_m1x2", MDU_MULT, 32'hFFFF_FFFF, 32'd2, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_m1x2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_min_sq", MDU_MULT, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'h0000_0000);
    run_op("multu_max_sq", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001);

    // MTHI while idle
    drive(MDU_MTHI, 32'h1234_5678, 32'd0);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    #1;
    chk("mthi_idle", HI_E, 32'h1234_5678);

    // Divides
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2, DC, 32'd1, 32'd3);
    run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD);
    run_op("div_m7_m2", MDU_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, DC, 32'hFFFF_FFFF, 32'd3);
    run_op("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
    run_op("divu_max_2", MDU_DIVU, 32'hFFFF_FFFF, 32'd2, DC, 32'd1, 32'h7FFF_FFFF);

    // Divide by zero leaves HI/LO unchanged
    drive(MDU_MTHI, 32'hAAAA_0000, 32'd0);
    tick();
    drive(MDU_MTLO, 32'h0000_BBBB, 32'd0);
    tick();
    run_op("div_by0", MDU_DIV, 32'd99, 32'd0, DC, 32'hAAAA_0000, 32'h0000_BBBB);
    run_op("divu_by0", MDU_DIVU, 32'd99, 32'd0, DC, 32'hAAAA_0000, 32'h0000_BBBB);

    // Reset during the third busy cycle aborts the multiply
    drive(MDU_MULT, 32'd6, 32'd7);
    tick();
    drive(MDU_NONE, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_mid_busy_before", {31'd0, busy_E}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy_E}, 32'd0);
    chk("rst_mid_hi", HI_E, 32'd0);
    chk("rst_mid_lo", LO_E, 32'd0);
    for (int i = 0; i < MC + 2; i++) tick();
    chk("rst_mid_busy_later", {31'd0, busy_E}, 32'd0);
    chk("rst_mid_hi_later", HI_E, 32'd0);
    chk("rst_mid_lo_later", LO_E, 32'd0);

    // Second op and MTLO while busy are ignored
    drive(MDU_MTLO, 32'h0000_0042, 32'd0);
    tick();
    drive(MDU_MULT, 32'd3, 32'd5);
    #1;
    chk("busy_first_start", {31'd0, start_E}, 32'd1);
    sb_q.push_back({32'd0, 32'd15});
    tick();
    drive(MDU_MULT, 32'd7, 32'd7);
    #1;
    chk("busy_second_start", {31'd0, start_E}, 32'd0);
    chk("busy_second_busy", {31'd0, busy_E}, 32'd1);
    tick();
    drive(MDU_MTLO, 32'h0000_DEAD, 32'd0);
    tick();
    chk("mtlo_busy_lo", LO_E, 32'h0000_0042);
    drive(MDU_MFLO, 32'd0, 32'd0);
    #1;
    chk("mflo_busy_old", MDOut_E, 32'h0000_0042);
    drive(MDU_NONE, 32'd0, 32'd0);
    wait_idle(cyc);
    chk("busy_seq_cycles", cyc, MC - 2);
    e = sb_q.pop_front();
    chk("busy_seq_hi", HI_E, e[63:32]);
    chk("busy_seq_lo", LO_E, e[31:0]);
    tick();
    chk("busy_seq_idle", {31'd0, busy_E}, 32'd0);
    chk("busy_seq_lo_hold", LO_E, 32'd15);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
Name: mdu_E

Overview:
- Execute-stage multiply/divide unit. It consumes the operand and control outputs of the D→E pipeline register (ALU1_E/ALU2_E, decoded MDU op).
- Holds the HI/LO architectural registers and runs mult/multu/div/divu as a fixed-latency multicycle operation.
- Exports busy/start so the D-stage hazard logic can stall dependent MDU instructions.
- Returns mfhi/mflo data to the E→M path.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, busy duration for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- A_E  input  32  operand rs (from ALU1_E)
- B_E  input  32  operand rt (from ALU2_E)
- MDUOp_E  input  4  op code from shared package (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
- start_E  output  1  combinational: MDUOp_E ∈ {MULT, MULTU, DIV, DIVU} and not busy_E
- busy_E  output  1  registered: operation in progress
- HI_E  output  32  current HI register
- LO_E  output  32  current LO register
- MDOut_E  output  32  HI when MDUOp_E=MFHI, LO when MFLO, else 0

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high. At a reset edge: HI=0, LO=0, busy_E=0, counter=0, pending result=0. Reset mid-operation aborts the operation and discards its result.
- States:
  - IDLE: busy_E=0, counter=0.
  - RUN: busy_E=1, counter counts down.
- IDLE→RUN: at the edge where start_E=1.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - The result is computed from A_E/B_E in that cycle and latched into the pending HI/LO registers.
  - Operands need not stay stable afterwards.
- RUN: counter decrements each edge. On the edge where counter==1: HI/LO ← pending, busy_E→0, return to IDLE.
- Latency: with start in cycle t, busy_E is high in cycles t+1..t+N. The new HI/LO values are visible from cycle t+N+1 (N = MULT_CYCLES or DIV_CYCLES).
- Arithmetic:
  - MULT: signed 32×32→64; HI = product[63:32], LO = product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero (B_E=0): operation still occupies DIV_CYCLES, but HI/LO are left unchanged at completion.
- MTHI/MTLO: when not busy, HI (or LO) ← A_E at the next edge. When busy_E=1 they are ignored; the hazard unit guarantees this does not occur.
- MFHI/MFLO: combinational read of the current HI/LO. Reads during busy return the old values; the hazard unit stalls these reads.
- A multicycle op arriving while busy_E=1 is ignored (start_E=0). Legal flow never produces this.
- NONE and unknown op codes: no state change.
- Stall contract for D-stage hazard logic: stall the D-stage MDU instruction when (start_E | busy_E).

Decomposition:
- Shared package (mips_defs): MDUOp encodings (4-bit localparams) and the MULT_CYCLES/DIV_CYCLES defaults.
- One natural sub-module, mdu_calc: purely combinational. Takes op, A, B; produces 64-bit {hi, lo} plus a div0 flag.
- mdu_E keeps the counter, FSM, pending and HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFF, B=2 → busy 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Check MFHI/MFLO return these in cycle t+6.
- MULTU A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. MTHI A=0x12345678 while idle → HI=0x12345678 next cycle.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIV with B=0, prior HI=0xAAAA0000, LO=0x0000BBBB → busy 10 cycles, then HI/LO unchanged.
- Start MULT, assert reset in 3rd busy cycle → next cycle busy_E=0, HI=LO=0, and the result is never written.
- MULT issued while busy (second op code held during RUN) → start_E=0. Only the first result is committed. MTLO during busy leaves LO unchanged.
